// File: rtl/fu_pkg.sv
// Shared definitions for the scalar FU family (multiplier, adder, accumulator).
package fu_pkg;
  localparam int FU_PROD_W = 64;
  localparam int FU_CNT_W  = 8;

  // Wide enough to sum 2^FU_CNT_W full-scale products without overflow.
  typedef logic [FU_PROD_W+FU_CNT_W-1:0] fu_acc_t;
endpackage

// File: rtl/result_slot.sv
// Single-entry result register with a valid/ready output handshake.
//
// Handshake: a result transfers on any rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_valid and out_data hold steady. out_data keeps its last value after
// a drain. A load on the same edge as a drain replaces the drained result.
module result_slot #(
  parameter int width = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [width-1:0] out_data,
  output logic             full
);

  // Load has priority over drain; the parent only asserts load when the
  // slot is empty or is draining on this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign full = out_valid;

endmodule

// File: rtl/accumulator_fu.sv
// Group accumulator behind the scalar multiplier: sums len products and
// presents each group sum through a one-entry valid/ready result slot.
// The input side never stalls; results that find the slot full are
// dropped and flagged through the sticky overrun output.
module accumulator_fu
  import fu_pkg::*;
#(
  parameter int in_width    = FU_PROD_W,
  parameter int count_width = FU_CNT_W,
  parameter int acc_width   = in_width + count_width
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   on_off,
  input  logic                   in_valid,
  input  logic [in_width-1:0]    in_data,
  input  logic [count_width-1:0] len,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [acc_width-1:0]   out_data,
  output logic                   busy,
  output logic                   overrun
);

  localparam logic [count_width-1:0] cnt_one = 1;

  logic [acc_width-1:0]   acc;
  logic [count_width-1:0] cnt;
  logic [count_width-1:0] len_q;

  logic                   accept;
  logic                   abort;
  logic [count_width-1:0] last;
  logic                   complete;
  logic [acc_width-1:0]   sum;
  logic                   slot_full;
  logic                   slot_load;
  logic [count_width-1:0] cnt_next;

  // Decode this cycle's accept/complete; len==0 wraps last to all-ones,
  // giving the 2^count_width group length.
  always_comb begin
    abort     = clear || !on_off;
    accept    = in_valid && !abort;
    last      = ((cnt == '0) ? len : len_q) - cnt_one;
    complete  = accept && (cnt == last);
    sum       = acc + {{(acc_width-in_width){1'b0}}, in_data};
    slot_load = complete && (!slot_full || out_ready);
    cnt_next  = cnt;
    if (abort || complete) begin
      cnt_next = '0;
    end else if (accept) begin
      cnt_next = cnt + cnt_one;
    end
  end

  // Accumulator, group counter, latched group length and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      busy  <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      busy <= (cnt_next != '0);
      if (accept && (cnt == '0)) begin
        len_q <= len;
      end
      if (abort || complete) begin
        acc <= '0;
      end else if (accept) begin
        acc <= sum;
      end
    end
  end

  // Sticky loss flag: set when a finished group meets a full, stalled slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (complete && slot_full && !out_ready) begin
      overrun <= 1'b1;
    end
  end

  result_slot #(
    .width(acc_width)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (slot_load),
    .load_data (sum),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (slot_full)
  );

endmodule

// File: tb/tb_accumulator_fu.sv
// Bench for accumulator_fu: directed scenarios with fixed expected values,
// then a randomized run against a group-level reference model.
module tb_accumulator_fu;
  import fu_pkg::*;

  logic          clk;
  logic          reset;
  logic          on_off;
  logic          in_valid;
  logic [63:0]   in_data;
  logic [7:0]    len;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [71:0]   out_data;
  logic          busy;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state: products of the open group, plus the slot.
  logic [71:0] grp_q[$];
  int          grp_len;
  logic        m_valid;
  logic [71:0] m_data;
  logic        m_ovr;

  accumulator_fu dut (
    .clk       (clk),
    .reset     (reset),
    .on_off    (on_off),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .len       (len),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    grp_q.delete();
    grp_len = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ovr   = 1'b0;
  endfunction

  // One clock edge of the behaviour, using the inputs seen at that edge.
  function automatic void model_edge();
    logic        done;
    logic [71:0] total;
    done  = 1'b0;
    total = '0;
    if (clear || !on_off) grp_q.delete();
    if (clear) m_ovr = 1'b0;
    if (in_valid && on_off && !clear) begin
      if (grp_q.size() == 0) grp_len = (len == 0) ? 256 : int'(len);
      grp_q.push_back({8'd0, in_data});
      if (grp_q.size() == grp_len) begin
        foreach (grp_q[i]) total += grp_q[i];
        grp_q.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1;
        m_data  = total;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endfunction

  // Driver: apply current inputs across one rising edge, sample 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic put(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; on_off = 1'b1; in_valid = 1'b0; in_data = '0;
    len = 8'd4; clear = 1'b0; out_ready = 1'b1;
    model_reset();
    #2;
    checks++;
    if ({out_valid, out_data, busy, overrun} !== 75'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h b=%b o=%b required all zero", out_valid, out_data, busy, overrun);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_sum();
    len = 8'd4; out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      put(64'(k));
      checks++;
      if (busy !== (k < 4)) begin
        errors++;
        $display("FAIL basic_busy: after product %0d got %b required %b", k, busy, (k < 4));
      end
      checks++;
      if (out_valid !== (k == 4)) begin
        errors++;
        $display("FAIL basic_valid: after product %0d got %b required %b", k, out_valid, (k == 4));
      end
    end
    checks++;
    if (out_data !== 72'd10) begin
      errors++;
      $display("FAIL basic_data: got %0d required 10", out_data);
    end
    idle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 72'd10) begin
      errors++;
      $display("FAIL basic_drain: got v=%b d=%0d required v=0 d=10", out_valid, out_data);
    end
  endtask

  task automatic test_max_width();
    len = 8'd0; out_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      put('1);
      if (k == 254) begin
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL max_partial: got v=%b busy=%b required v=0 busy=1", out_valid, busy);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 72'hFF_FFFF_FFFF_FFFF_FF00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL max_sum: got v=%b d=%h busy=%b required v=1 d=ffffffffffffffff00 busy=0", out_valid, out_data, busy);
    end
    idle();
  endtask

  task automatic test_overrun();
    len = 8'd2; out_ready = 1'b0;
    put(64'd5); put(64'd6);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 72'd11 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: got v=%b d=%0d o=%b required v=1 d=11 o=0", out_valid, out_data, overrun);
    end
    put(64'd7); put(64'd8);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 72'd11 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drop: got v=%b d=%0d o=%b required v=1 d=11 o=1", out_valid, out_data, overrun);
    end
    out_ready = 1'b1;
    idle();
    idle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 72'd11 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drain: got v=%b d=%0d o=%b required v=0 d=11 o=1", out_valid, out_data, overrun);
    end
    clear = 1'b1;
    idle();
    clear = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got %b required 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    len = 8'd1; out_ready = 1'b1;
    for (int k = 9; k <= 11; k++) begin
      put(64'(k));
      checks++;
      if (out_valid !== 1'b1 || out_data !== 72'(k) || overrun !== 1'b0) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b d=%0d o=%b required v=1 d=%0d o=0", k, out_valid, out_data, overrun, k);
      end
    end
    idle();
  endtask

  task automatic test_clear_on_off();
    out_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      len = 8'd3;
      put(64'd1); put(64'd2);
      if (pass == 0) clear = 1'b1; else on_off = 1'b0;
      put(64'd100);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_%0d: got busy=%b v=%b required busy=0 v=0", pass, busy, out_valid);
      end
      clear = 1'b0; on_off = 1'b1;
      put(64'd4); put(64'd5); put(64'd6);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 72'd15) begin
        errors++;
        $display("FAIL abort_sum_%0d: got v=%b d=%0d required v=1 d=15", pass, out_valid, out_data);
      end
      idle();
    end
  endtask

  task automatic test_async_reset();
    len = 8'd4; out_ready = 1'b1;
    put(64'd1); put(64'd2);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({out_valid, out_data, busy, overrun} !== 75'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%h b=%b o=%b required all zero", out_valid, out_data, busy, overrun);
    end
    @(negedge clk);
    reset = 1'b1;
    put(64'd10); put(64'd20); put(64'd30); put(64'd40);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 72'd100) begin
      errors++;
      $display("FAIL async_regroup: got v=%b d=%0d required v=1 d=100", out_valid, out_data);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      len       = 8'($urandom_range(1, 4));
      out_ready = $urandom_range(0, 1) == 1;
      clear     = ($urandom_range(0, 24) == 0);
      on_off    = ($urandom_range(0, 24) != 0);
      step();
      checks++;
      if (out_valid !== m_valid || (m_valid && out_data !== m_data)) begin
        errors++;
        $display("FAIL rand_slot cycle %0d: got v=%b d=%h required v=%b d=%h", n, out_valid, out_data, m_valid, m_data);
      end
      checks++;
      if (busy !== (grp_q.size() != 0) || overrun !== m_ovr) begin
        errors++;
        $display("FAIL rand_flags cycle %0d: got busy=%b o=%b required busy=%b o=%b", n, busy, overrun, (grp_q.size() != 0), m_ovr);
      end
    end
    in_valid = 1'b0; clear = 1'b0; on_off = 1'b1;
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic_sum();
    test_max_width();
    test_overrun();
    test_back_to_back();
    test_clear_on_off();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
